// File: rtl/mult_stream_sequencer.sv
// Streams operand pairs from a RAM into a pipelined multiplier and writes each
// product back at its source address, using a tag pipeline sized from the latencies.
module mult_stream_sequencer #(
  parameter int OP_WIDTH   = 63,
  parameter int RES_WIDTH  = 127,
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH:0]   vec_count,
  input  logic [15:0]           repeat_count,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [31:0]           run_cycles,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [OP_WIDTH-1:0]   rd_data_a,
  input  logic [OP_WIDTH-1:0]   rd_data_b,
  output logic [OP_WIDTH-1:0]   dut_x,
  output logic [OP_WIDTH-1:0]   dut_y,
  output logic                  dut_valid,
  input  logic [RES_WIDTH-1:0]  dut_p,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [RES_WIDTH-1:0]  wr_data
);

  // rd_en -> wr_en distance; the wr_en register itself is the last of the D stages
  localparam int D    = RD_LATENCY + LATENCY + 2;
  localparam int TAGS = D - 1;
  localparam logic [ADDR_WIDTH:0] MAX_N = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH:0]   n_cnt;
  logic [ADDR_WIDTH:0]   n_clamped;
  logic [15:0]           passes_left;
  logic [15:0]           r_eff;
  logic                  empty_run;
  logic                  accept;
  logic                  last_addr;
  logic                  last_pass;
  logic                  tags_busy;
  logic                  tag_vld  [TAGS];
  logic [ADDR_WIDTH-1:0] tag_addr [TAGS];

  assign n_clamped = (vec_count > MAX_N) ? MAX_N : vec_count;
  assign r_eff     = (repeat_count == 16'd0) ? 16'd1 : repeat_count;
  assign accept    = (state == IDLE) && start && !abort;
  assign last_addr = ({1'b0, rd_addr} == (n_cnt - 1'b1));
  assign last_pass = (passes_left == 16'd1);

  always_comb begin
    tags_busy = 1'b0;
    for (int i = 0; i < TAGS; i++) tags_busy = tags_busy | tag_vld[i];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (n_clamped == '0) ? DONE : ISSUE;
      ISSUE:   if (abort) state_next = IDLE;
               else if (last_addr && last_pass) state_next = DRAIN;
      DRAIN:   if (abort) state_next = IDLE;
               else if (!tags_busy) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Run control: address/pass counters, status flags, busy-cycle counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_en       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      run_cycles  <= '0;
      rd_addr     <= '0;
      n_cnt       <= '0;
      passes_left <= '0;
      empty_run   <= 1'b0;
    end else begin
      rd_en <= (state_next == ISSUE);
      busy  <= (state_next == ISSUE) || (state_next == DRAIN);
      // An empty run spends one cycle in DONE before its pulse
      done  <= !abort && (((state == DRAIN) && (state_next == DONE)) ||
                          ((state == DONE) && empty_run));
      if (accept) begin
        n_cnt       <= n_clamped;
        passes_left <= r_eff;
        empty_run   <= (n_clamped == '0);
        rd_addr     <= '0;
        aborted     <= 1'b0;
        run_cycles  <= '0;
      end else begin
        if (abort) aborted <= 1'b1;
        if (busy && (run_cycles != '1)) run_cycles <= run_cycles + 1'b1;
        if ((state == ISSUE) && !abort && !(last_addr && last_pass)) begin
          rd_addr <= last_addr ? '0 : rd_addr + 1'b1;
          if (last_addr) passes_left <= passes_left - 1'b1;
        end
      end
    end
  end

  // Tag pipeline: stage i holds the rd_en/rd_addr issued i+1 cycles ago
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAGS; i++) begin
        tag_vld[i]  <= 1'b0;
        tag_addr[i] <= '0;
      end
    end else begin
      tag_vld[0]  <= rd_en && !abort;
      tag_addr[0] <= rd_addr;
      for (int i = 1; i < TAGS; i++) begin
        tag_vld[i]  <= tag_vld[i-1] && !abort;
        tag_addr[i] <= tag_addr[i-1];
      end
    end
  end

  // Operand register to the multiplier and product capture to the result RAM
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dut_x     <= '0;
      dut_y     <= '0;
      dut_valid <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      dut_valid <= tag_vld[RD_LATENCY-1] && !abort;
      if (tag_vld[RD_LATENCY-1]) begin
        dut_x <= rd_data_a;
        dut_y <= rd_data_b;
      end
      wr_en <= tag_vld[TAGS-1] && !abort;
      if (tag_vld[TAGS-1]) begin
        wr_addr <= tag_addr[TAGS-1];
        wr_data <= dut_p;
      end
    end
  end

endmodule

// File: tb/tb_mult_stream_sequencer.sv
// Scoreboard bench: two sequencers (LATENCY=4/RD_LATENCY=1 and LATENCY=0/RD_LATENCY=2)
// driven by directed runs; a negedge monitor pops expected reads, writes and done pulses.
module tb_mult_stream_sequencer;
  localparam int OW = 16;
  localparam int RW = 32;
  localparam int AW = 8;

  typedef struct { int cyc; logic [AW-1:0] addr; logic [RW-1:0] data; } ev_t;
  typedef struct { int cyc; int runc; } dn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic          reset_s [2];
  logic          start_s [2];
  logic          abort_s [2];
  logic [AW:0]   vec_s   [2];
  logic [15:0]   rep_s   [2];
  logic          busy_s  [2];
  logic          done_s  [2];
  logic          aborted_s [2];
  logic [31:0]   runc_s  [2];
  logic          rd_en_s [2];
  logic [AW-1:0] rd_addr_s [2];
  logic [OW-1:0] x_s [2];
  logic [OW-1:0] y_s [2];
  logic          dut_valid_s [2];
  logic          wr_en_s [2];
  logic [AW-1:0] wr_addr_s [2];
  logic [RW-1:0] wr_data_s [2];

  ev_t rq [2][$];
  ev_t wq [2][$];
  dn_t dq [2][$];

  function automatic logic [OW-1:0] xv(input logic [AW-1:0] a);
    return OW'(a) * OW'(7) + OW'(3);
  endfunction

  function automatic logic [OW-1:0] yv(input logic [AW-1:0] a);
    return (OW'(a) * OW'(5) + OW'(1)) ^ 16'h8000;
  endfunction

  function automatic logic [RW-1:0] prod(input logic [AW-1:0] a);
    return RW'(xv(a)) * RW'(yv(a));
  endfunction

  // End-to-end rd_en -> wr_en distance for each instance
  function automatic int dlat(input int k);
    return (k == 0) ? 7 : 4;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  for (genvar k = 0; k < 2; k++) begin : g
    localparam int LAT = (k == 0) ? 4 : 0;
    localparam int RDL = (k == 0) ? 1 : 2;
    logic [OW-1:0] ra [RDL];
    logic [OW-1:0] rb [RDL];
    logic [RW-1:0] pc, dp;

    always @(posedge clk) begin
      ra[0] <= xv(rd_addr_s[k]);
      rb[0] <= yv(rd_addr_s[k]);
      for (int i = 1; i < RDL; i++) begin
        ra[i] <= ra[i-1];
        rb[i] <= rb[i-1];
      end
    end

    assign pc = RW'(x_s[k]) * RW'(y_s[k]);
    if (LAT == 0) begin : lat0
      assign dp = pc;
    end else begin : latn
      logic [RW-1:0] pq [LAT];
      always @(posedge clk) begin
        pq[0] <= pc;
        for (int i = 1; i < LAT; i++) pq[i] <= pq[i-1];
      end
      assign dp = pq[LAT-1];
    end

    mult_stream_sequencer #(
      .OP_WIDTH(OW), .RES_WIDTH(RW), .ADDR_WIDTH(AW), .LATENCY(LAT), .RD_LATENCY(RDL)
    ) u_dut (
      .clock(clk), .reset(reset_s[k]), .start(start_s[k]), .abort(abort_s[k]),
      .vec_count(vec_s[k]), .repeat_count(rep_s[k]),
      .busy(busy_s[k]), .done(done_s[k]), .aborted(aborted_s[k]), .run_cycles(runc_s[k]),
      .rd_en(rd_en_s[k]), .rd_addr(rd_addr_s[k]),
      .rd_data_a(ra[RDL-1]), .rd_data_b(rb[RDL-1]),
      .dut_x(x_s[k]), .dut_y(y_s[k]), .dut_valid(dut_valid_s[k]), .dut_p(dp),
      .wr_en(wr_en_s[k]), .wr_addr(wr_addr_s[k]), .wr_data(wr_data_s[k])
    );
  end

  always @(negedge clk) begin
    ev_t e;
    dn_t d;
    for (int k = 0; k < 2; k++) begin
      if (rd_en_s[k]) begin
        if (rq[k].size() == 0) chk($sformatf("rd_unexpected_u%0d", k), 1, 0);
        else begin
          e = rq[k].pop_front();
          chk($sformatf("rd_u%0d", k), {cyc, rd_addr_s[k]}, {e.cyc, e.addr});
        end
      end
      if (wr_en_s[k]) begin
        if (wq[k].size() == 0) chk($sformatf("wr_unexpected_u%0d", k), 1, 0);
        else begin
          e = wq[k].pop_front();
          chk($sformatf("wr_u%0d", k), {cyc, wr_addr_s[k], wr_data_s[k]}, {e.cyc, e.addr, e.data});
        end
      end
      if (done_s[k]) begin
        if (dq[k].size() == 0) chk($sformatf("done_unexpected_u%0d", k), 1, 0);
        else begin
          d = dq[k].pop_front();
          chk($sformatf("done_u%0d", k), {cyc, runc_s[k]}, {d.cyc, 32'(d.runc)});
        end
      end
    end
  end

  function automatic logic [127:0] outs(input int k);
    return 128'({busy_s[k], done_s[k], aborted_s[k], runc_s[k], rd_en_s[k], rd_addr_s[k],
                 x_s[k], y_s[k], dut_valid_s[k], wr_en_s[k], wr_addr_s[k], wr_data_s[k]});
  endfunction

  task automatic run(input int k, input int n, input int r, input int nrd, input int nwr,
                     input bit dn, output int s);
    int nc, rc, tot, dd;
    ev_t e;
    dn_t d;
    nc  = (n > 256) ? 256 : n;
    rc  = (r == 0) ? 1 : r;
    tot = nc * rc;
    dd  = dlat(k);
    if (nrd < 0 || nrd > tot) nrd = tot;
    if (nwr < 0 || nwr > tot) nwr = tot;
    @(posedge clk); #1;
    vec_s[k] = n[AW:0];
    rep_s[k] = r[15:0];
    start_s[k] = 1'b1;
    s = cyc;
    for (int i = 0; i < nrd; i++) begin
      e.cyc = s + 1 + i; e.addr = AW'(i % nc); e.data = '0;
      rq[k].push_back(e);
    end
    for (int i = 0; i < nwr; i++) begin
      e.cyc = s + 1 + i + dd; e.addr = AW'(i % nc); e.data = prod(e.addr);
      wq[k].push_back(e);
    end
    if (dn) begin
      d.cyc  = (nc == 0) ? s + 2 : s + tot + dd + 1;
      d.runc = (nc == 0) ? 0 : tot + dd;
      dq[k].push_back(d);
    end
    @(posedge clk); #1;
    start_s[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (!busy_s[k] && !done_s[k] && rq[k].size() == 0 && wq[k].size() == 0 &&
          dq[k].size() == 0) begin
        repeat (3) @(posedge clk);
        #1;
        return;
      end
    end
    chk($sformatf("idle_timeout_u%0d", k), 1, 0);
  endtask

  task automatic wait_cycle(input int t);
    while (cyc < t) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic abort_test(input int k);
    int s, dd;
    dd = dlat(k);
    run(k, 10, 1, dd + 3, 3, 1'b0, s);
    wait_cycle(s + dd + 3);
    abort_s[k] = 1'b1;
    @(posedge clk); #1;
    abort_s[k] = 1'b0;
    chk($sformatf("aborted_set_u%0d", k), aborted_s[k], 1);
    wait_idle(k);
    chk($sformatf("aborted_sticky_u%0d", k), aborted_s[k], 1);
    run(k, 3, 1, -1, -1, 1'b1, s);
    chk($sformatf("aborted_cleared_u%0d", k), aborted_s[k], 0);
    wait_idle(k);
  endtask

  task automatic reset_test(input int k);
    int s;
    run(k, 3, 1, -1, 0, 1'b0, s);
    wait_cycle(s + 5);
    #1 reset_s[k] = 1'b1;
    #1 chk($sformatf("reset_mid_drain_u%0d", k), outs(k), 0);
    @(posedge clk); #1;
    reset_s[k] = 1'b0;
    chk($sformatf("reset_hold_u%0d", k), outs(k), 0);
    repeat (3) @(posedge clk);
    run(k, 5, 2, -1, -1, 1'b1, s);
    wait_idle(k);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    logic any_busy;
    for (int k = 0; k < 2; k++) begin
      reset_s[k] = 1'b1; start_s[k] = 1'b0; abort_s[k] = 1'b0;
      vec_s[k] = '0; rep_s[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) chk($sformatf("reset_state_u%0d", k), outs(k), 0);
    for (int k = 0; k < 2; k++) reset_s[k] = 1'b0;

    run(0, 3, 1, -1, -1, 1'b1, s);
    wait_idle(0);

    // Second start mid-run must be ignored
    run(0, 4, 3, -1, -1, 1'b1, s);
    wait_cycle(s + 4);
    vec_s[0] = 9'd2; start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    wait_idle(0);

    run(0, 0, 1, -1, -1, 1'b1, s);
    any_busy = 1'b0;
    repeat (3) begin
      any_busy = any_busy | busy_s[0];
      @(posedge clk); #1;
    end
    chk("empty_run_busy", any_busy, 0);
    wait_idle(0);

    run(0, 256, 2, -1, -1, 1'b1, s);
    wait_idle(0);
    run(0, 300, 1, -1, -1, 1'b1, s);
    wait_idle(0);

    // start and abort together in IDLE: abort wins
    @(posedge clk); #1;
    vec_s[0] = 9'd3; start_s[0] = 1'b1; abort_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0; abort_s[0] = 1'b0;
    chk("start_abort_aborted", aborted_s[0], 1);
    chk("start_abort_busy", busy_s[0], 0);
    repeat (4) @(posedge clk);
    run(0, 2, 0, -1, -1, 1'b1, s);
    wait_idle(0);

    abort_test(0);
    reset_test(0);

    run(1, 3, 1, -1, -1, 1'b1, s);
    wait_idle(1);
    run(1, 4, 2, -1, -1, 1'b1, s);
    wait_idle(1);
    abort_test(1);
    reset_test(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_stream_sequencer.md
Name: mult_stream_sequencer

Overview:
- Parametrised successor to the fixed-pipeline multiplier test harness.
- Drives operand pairs from the operand RAM into a multiplier DUT of any pipeline depth, one pair per clock.
- Aligns each result with its source address through an internal tag pipeline sized from parameters, so no hand-placed delay stages are needed.
- Writes results to the result RAM; supports back-to-back repeated passes, abort, and a cycle count for throughput measurement.

Parameters:
OP_WIDTH, 63, width of each operand word (x and y)
RES_WIDTH, 127, width of DUT product word
ADDR_WIDTH, 8, operand/result RAM address width
LATENCY, 4, DUT pipeline depth: product valid LATENCY cycles after operands are presented
RD_LATENCY, 1, operand RAM read latency in cycles (>=1)

Ports:
clock  in  1  single clock for all logic
reset  in  1  asynchronous, active-high reset
start  in  1  begin run; sampled only in IDLE
abort  in  1  terminate run; sampled in any state
vec_count  in  ADDR_WIDTH+1  vectors per pass; 0 = empty run; >2^ADDR_WIDTH clamped
repeat_count  in  16  passes per run; 0 treated as 1
busy  out  1  high in ISSUE and DRAIN
done  out  1  one-cycle pulse at normal completion
aborted  out  1  sticky; set by abort, cleared by next accepted start
run_cycles  out  32  clocks spent busy in current/last run; saturates
rd_en  out  1  operand RAM read enable
rd_addr  out  ADDR_WIDTH  operand RAM read address
rd_data_a  in  OP_WIDTH  operand x read data
rd_data_b  in  OP_WIDTH  operand y read data
dut_x  out  OP_WIDTH  registered operand x to DUT
dut_y  out  OP_WIDTH  registered operand y to DUT
dut_valid  out  1  dut_x/dut_y hold a live vector
dut_p  in  RES_WIDTH  DUT product
wr_en  out  1  result RAM write enable
wr_addr  out  ADDR_WIDTH  result RAM write address
wr_data  out  RES_WIDTH  registered product

Behaviour:
- Reset: all outputs 0; state IDLE; tag pipeline cleared.
- All outputs registered.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 and abort=0: latch clamped vec_count N and passes R, clear run_cycles and aborted.
  - N>0: next state ISSUE. N=0: next state DONE with no reads or writes.
- ISSUE:
  - rd_en=1 each cycle; rd_addr runs 0..N-1.
  - After address N-1: if passes remain, the next cycle issues address 0 with no bubble; otherwise go to DRAIN.
- Alignment:
  - rd_data is sampled RD_LATENCY cycles after rd_en, registered into dut_x/dut_y with dut_valid=1.
  - dut_p is captured LATENCY cycles later into wr_data, with wr_en=1 and wr_addr = the issuing rd_addr.
  - End-to-end: wr_en asserts exactly D = RD_LATENCY+LATENCY+2 cycles after the matching rd_en.
  - Address/valid tags travel through a D-deep shift register; data does not.
- DRAIN: rd_en=0; move to DONE on the cycle after the last valid tag produces its write, i.e. D cycles after the last rd_en.
- DONE: done=1 for one cycle, then IDLE.
- run_cycles increments on every cycle busy=1; saturates at 2^32-1.
- Abort (any state, including mid-ISSUE or DRAIN):
  - Next state IDLE; all tag valids cleared, so no wr_en from the next cycle on.
  - rd_en and dut_valid drop next cycle; aborted=1; no done pulse.
- Simultaneous events:
  - start and abort in the same IDLE cycle: abort wins, start is ignored.
  - start while busy is ignored.
- dut_x/dut_y hold their last value when dut_valid=0.

Test Plan:
- LATENCY=4, RD_LATENCY=1, N=3, R=1, start at cycle 0 -> rd_en cycles 1-3, addrs 0,1,2; wr_en cycles 8-10, wr_addr 0,1,2, wr_data = DUT products of the matching pairs; done pulse cycle 11; run_cycles=10.
- N=4, R=3 -> 12 consecutive rd_en cycles, addresses 0,1,2,3 repeating with no gap; 12 writes in order; single done; run_cycles=19.
- N=0, start -> done pulse 2 cycles after start; rd_en and wr_en never assert; busy never asserts.
- N=256 (ADDR_WIDTH=8) and N=300 -> both issue exactly 256 reads; rd_addr wraps 255->0 only when R>1.
- Abort 2 cycles after first wr_en in a 10-vector run -> at most writes for addrs 0-2 occur; wr_en=0 thereafter; aborted=1, done never pulses; a following start clears aborted and completes normally.
- Reset asserted mid-DRAIN -> all outputs 0 immediately; no further writes; a later start behaves as a fresh run. Repeat with LATENCY=0 and RD_LATENCY=2 -> D=4 alignment holds.
